dma_peripheral_requester: RTL and testbench

//  Peripheral-side end of the DREQ/DACK/EOP handshake: one I/O device channel that requests DMA service.

---
 rtl/dma_peripheral_requester_pkg.sv | 20 ++
 rtl/dma_peripheral_requester_fifo.sv | 73 +++++++
 rtl/dma_peripheral_requester.sv | 157 +++++++++++++++
 tb/tb_dma_peripheral_requester.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_peripheral_requester_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_peripheral_requester_pkg                                         |
// | Shared states and direction encodings for the DMA peripheral end.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dma_peripheral_requester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    HOLD = 2'd3
  } periphState_t;

  localparam logic DIR_IO2MEM = 1'b0;
  localparam logic DIR_MEM2IO = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dma_peripheral_requester_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_peripheral_requester_fifo                                        |
// | DEPTH x DW synchronous FIFO with simultaneous push/pop.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dma_peripheral_requester_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push_i,
  input  logic [DW-1:0] pushData_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] c_CNT_MAX = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_doPush;
  logic          w_doPop;

  assign full_o   = (count_q == c_CNT_MAX);
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign head_o   = mem_q[rdPtr_q];
  assign w_doPush = push_i & ~full_o;
  assign w_doPop  = pop_i & ~empty_o;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_comb begin
    wrPtr_d = w_doPush ? wrPtr_q + c_PTR_ONE : wrPtr_q;
    rdPtr_d = w_doPop ? rdPtr_q + c_PTR_ONE : rdPtr_q;
    count_d = count_q;
    if (w_doPush && !w_doPop) begin
      count_d = count_q + c_CNT_ONE;
    end else if (!w_doPush && w_doPop) begin
      count_d = count_q - c_CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_peripheral_requester.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_peripheral_requester                                             |
// | Peripheral side of the DREQ/DACK/EOP handshake for one DMA channel.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dma_peripheral_requester
  import dma_peripheral_requester_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DW        = 8,
  parameter int THRESHOLD = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          enable,
  input  logic          dir,
  input  logic          demandMode,
  output logic          DREQ,
  input  logic          DACK,
  input  logic          EOP_N,
  input  logic          IOR_N,
  input  logic          IOW_N,
  input  logic [DW-1:0] DB_IN,
  output logic [DW-1:0] DB_OUT,
  output logic          DB_OE,
  input  logic          pushValid,
  input  logic [DW-1:0] pushData,
  output logic          pushReady,
  output logic          popValid,
  output logic [DW-1:0] popData,
  input  logic          popReady,
  output logic          tcFlag,
  output logic          errFlag,
  input  logic          clrFlags
);

  localparam int            CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] c_THRESH    = CW'(THRESHOLD);
  localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

  periphState_t  state_q, state_d;
  logic          tc_q, tc_d;
  logic          err_q, err_d;
  logic          rdLow_q, wrLow_q;
  logic [DW-1:0] dbIn_q, dbIn_d;
  logic [DW-1:0] dbOut_q, dbOut_d;

  logic [DW-1:0] w_head;
  logic [DW-1:0] w_headOut;
  logic [DW-1:0] w_fifoData;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cntNext;
  logic          w_full, w_empty;
  logic          w_rdDone, w_wrDone, w_xferDone;
  logic          w_localPush, w_localPop, w_dmaPush, w_dmaPop;
  logic          w_fifoPush, w_fifoPop;
  logic          w_ready, w_readyNext, w_eop;

  dma_peripheral_requester_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push_i     (w_fifoPush),
    .pushData_i (w_fifoData),
    .pop_i      (w_fifoPop),
    .head_o     (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .count_o    (w_count)
  );

  // A strobe completes on its rising edge, and only if DACK was present while it was low.
  assign w_rdDone   = (dir == DIR_IO2MEM) & rdLow_q & IOR_N;
  assign w_wrDone   = (dir == DIR_MEM2IO) & wrLow_q & IOW_N;
  assign w_xferDone = (dir == DIR_IO2MEM) ? w_rdDone : w_wrDone;
  assign w_eop      = ~EOP_N & DACK;

  assign w_localPush = pushValid & ~w_full & (dir == DIR_IO2MEM);
  assign w_localPop  = popReady & ~w_empty & (dir == DIR_MEM2IO);
  assign w_dmaPush   = w_wrDone & ~w_full;
  assign w_dmaPop    = w_rdDone & ~w_empty;
  assign w_fifoPush  = w_localPush | w_dmaPush;
  assign w_fifoPop   = w_localPop | w_dmaPop;
  assign w_fifoData  = (dir == DIR_MEM2IO) ? dbIn_q : pushData;
  assign w_cntNext   = w_count + (w_fifoPush ? c_CNT_ONE : '0) - (w_fifoPop ? c_CNT_ONE : '0);

  assign w_ready     = (dir == DIR_IO2MEM) ? (w_count >= c_THRESH)
                                           : ((c_DEPTH_CNT - w_count) >= c_THRESH);
  assign w_readyNext = (dir == DIR_IO2MEM) ? (w_cntNext >= c_THRESH)
                                           : ((c_DEPTH_CNT - w_cntNext) >= c_THRESH);

  assign w_headOut = w_empty ? {DW{1'b1}} : w_head;
  assign DB_OE     = DACK & ~IOR_N & (dir == DIR_IO2MEM);
  assign DB_OUT    = DB_OE ? w_headOut : dbOut_q;
  assign DREQ      = (state_q == REQ) || (state_q == XFER);
  assign pushReady = ~w_full;
  assign popValid  = ~w_empty;
  assign popData   = w_head;
  assign tcFlag    = tc_q;
  assign errFlag   = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable && w_ready && !tc_q) state_d = REQ;
      REQ: begin
        if (!enable)   state_d = IDLE;
        else if (DACK) state_d = XFER;
      end
      XFER: begin
        if (!enable)                       state_d = HOLD;
        else if (w_xferDone && !demandMode) state_d = HOLD;
        else if (demandMode && !w_readyNext) state_d = HOLD;
        else if (!DACK && !w_xferDone)     state_d = REQ;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (w_eop) state_d = IDLE;
  end

  // Clear first so a coincident set takes priority.
  always_comb begin
    tc_d  = clrFlags ? 1'b0 : tc_q;
    err_d = clrFlags ? 1'b0 : err_q;
    if (w_eop) tc_d = 1'b1;
    if ((w_rdDone && w_empty) || (w_wrDone && w_full)) err_d = 1'b1;
    dbIn_d  = (~IOW_N & DACK) ? DB_IN : dbIn_q;
    dbOut_d = DB_OE ? w_headOut : dbOut_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      rdLow_q <= 1'b0;
      wrLow_q <= 1'b0;
      dbIn_q  <= '0;
      dbOut_q <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      rdLow_q <= ~IOR_N & DACK;
      wrLow_q <= ~IOW_N & DACK;
      dbIn_q  <= dbIn_d;
      dbOut_q <= dbOut_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_peripheral_requester.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dma_peripheral_requester                                          |
// | Scenario bench with a data scoreboard for dma_peripheral_requester.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dma_peripheral_requester;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RESET, enable, dir, demandMode, DACK, EOP_N, IOR_N, IOW_N;
  logic          pushValid, popReady, clrFlags;
  logic [DW-1:0] DB_IN, pushData;
  logic          DREQ, DB_OE, pushReady, popValid, tcFlag, errFlag;
  logic [DW-1:0] DB_OUT, popData;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];

  dma_peripheral_requester #(.DEPTH(8), .DW(DW), .THRESHOLD(1)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .dir(dir), .demandMode(demandMode),
    .DREQ(DREQ), .DACK(DACK), .EOP_N(EOP_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .pushValid(pushValid), .pushData(pushData), .pushReady(pushReady),
    .popValid(popValid), .popData(popData), .popReady(popReady),
    .tcFlag(tcFlag), .errFlag(errFlag), .clrFlags(clrFlags)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_local(input logic [DW-1:0] d);
    pushValid = 1'b1;
    pushData  = d;
    exp_q.push_back(d);
    tick();
    pushValid = 1'b0;
  endtask

  task automatic ior_pulse(output logic [DW-1:0] obs, output logic oe);
    IOR_N = 1'b0;
    tick();
    obs = DB_OUT;
    oe  = DB_OE;
    IOR_N = 1'b1;
    tick();
  endtask

  task automatic iow_pulse(input logic [DW-1:0] d);
    IOW_N = 1'b0;
    DB_IN = d;
    tick();
    IOW_N = 1'b1;
    tick();
  endtask

  task automatic wait_dreq();
    for (int i = 0; i < 10 && DREQ !== 1'b1; i++) tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; enable = 1'b0; dir = 1'b0; demandMode = 1'b0; DACK = 1'b0;
    EOP_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; pushValid = 1'b0; popReady = 1'b0;
    clrFlags = 1'b0; DB_IN = '0; pushData = '0;
    tick(); tick();
    RESET = 1'b0;
    tick();
    vectors++; if (DREQ !== 1'b0)    begin miscompares++; $display("FAIL reset_dreq: got %b want 0", DREQ); end
    vectors++; if (DB_OUT !== 8'h00) begin miscompares++; $display("FAIL reset_dbout: got %h want 00", DB_OUT); end
    vectors++; if (DB_OE !== 1'b0)   begin miscompares++; $display("FAIL reset_dboe: got %b want 0", DB_OE); end
    vectors++; if ({tcFlag, errFlag} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b%b want 00", tcFlag, errFlag); end
    vectors++; if ({popValid, pushReady} !== 2'b01) begin miscompares++; $display("FAIL reset_ready: got pv=%b pr=%b want pv=0 pr=1", popValid, pushReady); end
  endtask

  task automatic test_single_read();
    logic [DW-1:0] obs, exp;
    logic oe;
    enable = 1'b1; dir = 1'b0; demandMode = 1'b0;
    push_local(8'hA5);
    vectors++; if (DREQ !== 1'b0) begin miscompares++; $display("FAIL single_dreq_early: got %b want 0", DREQ); end
    tick();
    vectors++; if (DREQ !== 1'b1) begin miscompares++; $display("FAIL single_dreq_latency: got %b want 1", DREQ); end
    DACK = 1'b1;
    ior_pulse(obs, oe);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
    vectors++; if (obs !== exp)  begin miscompares++; $display("FAIL single_data: got %h want %h", obs, exp); end
    vectors++; if (oe !== 1'b1)  begin miscompares++; $display("FAIL single_oe: got %b want 1", oe); end
    vectors++; if (DREQ !== 1'b0) begin miscompares++; $display("FAIL single_dreq_drop: got %b want 0", DREQ); end
    DACK = 1'b0;
    tick();
    vectors++; if (DREQ !== 1'b0) begin miscompares++; $display("FAIL single_hold: got %b want 0", DREQ); end
  endtask

  task automatic test_demand_read();
    logic [DW-1:0] obs, exp;
    logic oe;
    demandMode = 1'b1;
    push_local(8'h11); push_local(8'h22); push_local(8'h33);
    wait_dreq();
    vectors++; if (DREQ !== 1'b1) begin miscompares++; $display("FAIL demand_req: got %b want 1", DREQ); end
    DACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ior_pulse(obs, oe);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
      vectors++; if (obs !== exp) begin miscompares++; $display("FAIL demand_data[%0d]: got %h want %h", i, obs, exp); end
      vectors++; if (DREQ !== (i < 2)) begin miscompares++; $display("FAIL demand_dreq[%0d]: got %b want %b", i, DREQ, (i < 2)); end
    end
    DACK = 1'b0;
    tick();
  endtask

  task automatic test_demand_write();
    logic [DW-1:0] exp;
    dir = 1'b1;
    wait_dreq();
    vectors++; if (DREQ !== 1'b1) begin miscompares++; $display("FAIL write_req: got %b want 1", DREQ); end
    DACK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(i));
      iow_pulse(8'(i));
    end
    vectors++; if (DREQ !== 1'b0)      begin miscompares++; $display("FAIL write_full_dreq: got %b want 0", DREQ); end
    vectors++; if (pushReady !== 1'b0) begin miscompares++; $display("FAIL write_full_ready: got %b want 0", pushReady); end
    vectors++; if (errFlag !== 1'b0)   begin miscompares++; $display("FAIL write_err_early: got %b want 0", errFlag); end
    iow_pulse(8'hEE);
    vectors++; if (errFlag !== 1'b1)   begin miscompares++; $display("FAIL write_overflow: got %b want 1", errFlag); end
    DACK = 1'b0;
    popReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
      vectors++; if ({popValid, popData} !== {1'b1, exp}) begin miscompares++; $display("FAIL write_pop[%0d]: got v=%b %h want v=1 %h", i, popValid, popData, exp); end
      tick();
    end
    popReady = 1'b0;
    vectors++; if (popValid !== 1'b0) begin miscompares++; $display("FAIL write_drained: got %b want 0", popValid); end
  endtask

  task automatic test_eop();
    logic [DW-1:0] obs, exp;
    logic oe;
    bit seen;
    enable = 1'b0; dir = 1'b0; clrFlags = 1'b1;
    tick();
    clrFlags = 1'b0;
    tick();
    push_local(8'h51); push_local(8'h52); push_local(8'h53); push_local(8'h54);
    enable = 1'b1;
    wait_dreq();
    DACK = 1'b1;
    ior_pulse(obs, oe);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
    vectors++; if (obs !== exp) begin miscompares++; $display("FAIL eop_data1: got %h want %h", obs, exp); end
    IOR_N = 1'b0; EOP_N = 1'b0;
    tick();
    obs = DB_OUT;
    IOR_N = 1'b1; EOP_N = 1'b1;
    tick();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
    vectors++; if (obs !== exp)     begin miscompares++; $display("FAIL eop_data2: got %h want %h", obs, exp); end
    vectors++; if (tcFlag !== 1'b1) begin miscompares++; $display("FAIL eop_tc: got %b want 1", tcFlag); end
    vectors++; if (DREQ !== 1'b0)   begin miscompares++; $display("FAIL eop_dreq: got %b want 0", DREQ); end
    DACK = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= DREQ;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL eop_no_rerequest: got %b want 0", seen); end
    clrFlags = 1'b1;
    tick();
    clrFlags = 1'b0;
    vectors++; if (tcFlag !== 1'b0) begin miscompares++; $display("FAIL eop_clear: got %b want 0", tcFlag); end
    wait_dreq();
    vectors++; if (DREQ !== 1'b1) begin miscompares++; $display("FAIL eop_rerequest: got %b want 1", DREQ); end
    DACK = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ior_pulse(obs, oe);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
      vectors++; if (obs !== exp) begin miscompares++; $display("FAIL eop_drain[%0d]: got %h want %h", i, obs, exp); end
    end
    DACK = 1'b0;
    tick();
  endtask

  task automatic test_underflow();
    logic [DW-1:0] obs, exp;
    logic oe;
    dir = 1'b0; DACK = 1'b1;
    vectors++; if (errFlag !== 1'b0) begin miscompares++; $display("FAIL under_err_early: got %b want 0", errFlag); end
    ior_pulse(obs, oe);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
    vectors++; if (obs !== exp)       begin miscompares++; $display("FAIL under_data: got %h want %h", obs, exp); end
    vectors++; if (DB_OUT !== 8'hFF)  begin miscompares++; $display("FAIL under_held: got %h want ff", DB_OUT); end
    vectors++; if (errFlag !== 1'b1)  begin miscompares++; $display("FAIL under_err: got %b want 1", errFlag); end
    vectors++; if ({popValid, pushReady} !== 2'b01) begin miscompares++; $display("FAIL under_count: got pv=%b pr=%b want pv=0 pr=1", popValid, pushReady); end
    DACK = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    push_local(8'h61); push_local(8'h62); push_local(8'h63); push_local(8'h64);
    wait_dreq();
    DACK = 1'b1; IOR_N = 1'b0;
    tick();
    RESET = 1'b1; IOR_N = 1'b1; DACK = 1'b0;
    tick();
    exp_q.delete();
    vectors++; if (DREQ !== 1'b0) begin miscompares++; $display("FAIL rst_dreq: got %b want 0", DREQ); end
    vectors++; if ({popValid, pushReady} !== 2'b01) begin miscompares++; $display("FAIL rst_count: got pv=%b pr=%b want pv=0 pr=1", popValid, pushReady); end
    vectors++; if ({tcFlag, errFlag} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b%b want 00", tcFlag, errFlag); end
    vectors++; if ({DB_OE, DB_OUT} !== 9'h000) begin miscompares++; $display("FAIL rst_bus: got oe=%b %h want oe=0 00", DB_OE, DB_OUT); end
    RESET = 1'b0;
    tick(); tick();
    vectors++; if (DREQ !== 1'b0) begin miscompares++; $display("FAIL rst_idle: got %b want 0", DREQ); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_demand_read();
    test_demand_write();
    test_eop();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
